multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control sequencer for the MIPS subset datapath (addu, subu, sll, ori, lw, sw, beq, j). Replaces the single-cycle combinational decoder with an FSM: shared instruction/data memory port with wait states, per-state datapath strobes, retire counter and trap on illegal opcode or memory timeout. Sits between the instruction register (IR) and the datapath muxes, ALU, register file and memory.

## Interface
- MEM_TIMEOUT, 15: maximum wait cycles in MEM before trap (1..255).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst  in  32  IR contents; stable except after the IF cycle.
- zero  in  1  ALU zero flag.
- dm_ready  in  1  data memory access complete this cycle.
- InstM_R  out  1  instruction memory read.
- IR_W  out  1  load IR from instruction memory.
- PC_W  out  1  write PC.
- PC_Src  out  2  00 = PC+4, 01 = branch target, 10 = jump target.
- ALUCtrl  out  3  000 add, 001 sub, 010 or, 011 sll.
- ALUSrcB  out  1  0 = rt register, 1 = extended immediate.
- ExtSigned  out  1  1 = sign-extend imm16 (lw/sw), 0 = zero-extend (ori).
- RegDst  out  1  0 = rd, 1 = rt.
- MemtoReg  out  1  1 = write-back data from memory.
- RF_W  out  1  register file write.
- DataM_CS, DataM_R, DataM_W  out  1 each  data memory chip select, read and write.
- state  out  3  current state encoding.
- trap  out  1  high while in TRAP.
- inst_cnt  out  32  retired instruction count.

## Operation
- States: IF = 0, ID = 1, EX = 2, MEM = 3, WB = 4, TRAP = 7.
- Opcodes:
  - R-format is op = 000000, with func 100001 addu, 100011 subu, 000000 sll.
  - ori = 001101, lw = 100011, sw = 101011, beq = 000100, j = 000010.
  - Any other op/func is illegal.
- IF:
  - Asserts InstM_R = 1, IR_W = 1 and PC_W = 1 with PC_Src = 00.
  - Next state is ID.
- ID:
  - j: PC_W = 1 with PC_Src = 10; retires; next state IF.
  - Illegal instruction: next state TRAP.
  - Otherwise: next state EX.
- EX:
  - ALUCtrl per instruction. ALUSrcB = 1 for ori, lw and sw.
  - ExtSigned = 1 for lw and sw.
  - R-type or ori: next state WB.
  - lw or sw: next state MEM.
  - beq: ALUCtrl = 001. If zero = 1, PC_W = 1 with PC_Src = 01. Retires; next state IF.
- MEM:
  - DataM_CS = 1; DataM_R = lw; DataM_W = sw. ALUCtrl = 000 and ALUSrcB = 1 are held so the address stays stable.
  - Strobes are held until dm_ready = 1.
  - On dm_ready: lw goes to WB; sw retires and goes to IF.
  - Wait counter (8 bit) clears on MEM entry and increments each cycle with dm_ready = 0.
  - When the counter reaches MEM_TIMEOUT with dm_ready still 0, next state is TRAP. dm_ready = 1 on that same cycle wins: no trap.
- WB:
  - RF_W = 1.
  - RegDst = 1 and MemtoReg = 0 for ori.
  - RegDst = 1 and MemtoReg = 1 for lw.
  - RegDst = 0 and MemtoReg = 0 for R-type.
  - Retires; next state IF.
- TRAP:
  - All strobes are 0 and trap = 1.
  - The FSM stays in TRAP until rst.
- Retire: inst_cnt increments by 1 on the clock edge that leaves the retiring state. It wraps from 0xFFFFFFFF to 0.
- Outputs not listed for a state are 0, except ALUCtrl = 000, PC_Src = 00 and ExtSigned = 0.

## Timing
- Outputs are combinational from state and inst only (Moore with respect to state). zero gates PC_W only in EX.
- Reset values, while rst is high and on release:
  - state = IF (0), wait counter = 0, inst_cnt = 0, trap = 0.
  - All strobes are forced to 0 while rst is high.
- The first IF strobes appear in the first full cycle after rst deasserts.
- Cycles per instruction:
  - j: 2.
  - beq: 3.
  - addu, subu, sll, ori: 4.
  - sw: 4 + w.
  - lw: 5 + w.
  - w is the number of MEM cycles with dm_ready = 0.
- Reset asserted mid-MEM drops DataM_CS/R/W immediately (asynchronous). No partial retire is counted.
- dm_ready outside MEM is ignored.

## Test plan
- Reset, then IR = addu (0x00851021): states IF, ID, EX, WB. RF_W = 1 only in cycle 4 with RegDst = 0. inst_cnt = 1 after 4 cycles.
- lw (0x8C820004) with dm_ready low for 3 cycles: MEM lasts 4 cycles with DataM_CS = DataM_R = 1 throughout, then WB with MemtoReg = 1 and RegDst = 1. Total 8 cycles.
- beq (0x10850003):
  - zero = 1: PC_W = 1 and PC_Src = 01 in EX.
  - zero = 0: no PC_W in EX.
  - Both cases take 3 cycles and increment inst_cnt.
- j (0x08000010): PC_W = 1 with PC_Src = 10 in ID, back to IF at cycle 3. Illegal op 0x3F: TRAP after ID, trap = 1, held for 20 cycles, cleared by rst.
- sw with dm_ready never asserted and MEM_TIMEOUT = 15: TRAP entered after 16 MEM cycles. Repeat with dm_ready arriving on the 16th MEM cycle: no trap, retire.
- rst pulsed mid-MEM: DataM_CS falls in the same cycle, state = 0, inst_cnt = 0. Separately, preload inst_cnt to 0xFFFFFFFF via 2^32-1 retires (force) then one retire: inst_cnt = 0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Bundles the signals between the multi-cycle sequencer and the MIPS datapath.
// The sequencer uses the master side. The datapath (or a testbench) uses the slave side.
interface multicycle_ctrl_if;
    // Datapath -> sequencer
    logic [31:0] inst;
    logic        zero;
    logic        dm_ready;

    // Sequencer -> datapath
    logic        InstM_R;
    logic        IR_W;
    logic        PC_W;
    logic [1:0]  PC_Src;
    logic [2:0]  ALUCtrl;
    logic        ALUSrcB;
    logic        ExtSigned;
    logic        RegDst;
    logic        MemtoReg;
    logic        RF_W;
    logic        DataM_CS;
    logic        DataM_R;
    logic        DataM_W;
    logic [2:0]  state;
    logic        trap;
    logic [31:0] inst_cnt;

    modport master (
        input  inst, zero, dm_ready,
        output InstM_R, IR_W, PC_W, PC_Src, ALUCtrl, ALUSrcB, ExtSigned,
               RegDst, MemtoReg, RF_W, DataM_CS, DataM_R, DataM_W,
               state, trap, inst_cnt
    );

    modport slave (
        output inst, zero, dm_ready,
        input  InstM_R, IR_W, PC_W, PC_Src, ALUCtrl, ALUSrcB, ExtSigned,
               RegDst, MemtoReg, RF_W, DataM_CS, DataM_R, DataM_W,
               state, trap, inst_cnt
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the MIPS subset datapath
// (addu, subu, sll, ori, lw, sw, beq, j).
// A single shared memory port is used for fetch and data. MEM waits for dm_ready.
// A bounded wait counter and an illegal-opcode detector both lead to a sticky TRAP.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLL   = 6'b000000;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  waitCnt_q, waitCnt_d;
    logic [31:0] instCnt_q, instCnt_d;
    logic        retire;

    logic [5:0]  op;
    logic [5:0]  func;
    logic        isAddu, isSubu, isSll, isRtype, isOri, isLw, isSw, isBeq, isJ, isLegal;
    logic        unusedInstBits;

    assign op             = bus.inst[31:26];
    assign func           = bus.inst[5:0];
    assign unusedInstBits = ^bus.inst[25:6];

    // Decode the IR. Only the opcode and funct fields matter to the sequencer.
    always_comb begin
        isAddu  = (op == OP_RTYPE) && (func == FN_ADDU);
        isSubu  = (op == OP_RTYPE) && (func == FN_SUBU);
        isSll   = (op == OP_RTYPE) && (func == FN_SLL);
        isRtype = isAddu || isSubu || isSll;
        isOri   = (op == OP_ORI);
        isLw    = (op == OP_LW);
        isSw    = (op == OP_SW);
        isBeq   = (op == OP_BEQ);
        isJ     = (op == OP_J);
        isLegal = isRtype || isOri || isLw || isSw || isBeq || isJ;
    end

    // Next-state logic. It also works out the MEM wait counter and which state retires.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        retire    = 1'b0;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                if (isJ) begin
                    state_d = S_IF;
                    retire  = 1'b1;
                end else if (!isLegal) begin
                    state_d = S_TRAP;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                if (isBeq) begin
                    state_d = S_IF;
                    retire  = 1'b1;
                end else if (isLw || isSw) begin
                    state_d   = S_MEM;
                    waitCnt_d = 8'd0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // A ready on the last allowed cycle still completes the access.
                if (bus.dm_ready) begin
                    if (isLw) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_IF;
                        retire  = 1'b1;
                    end
                end else if (waitCnt_q == WAIT_LIMIT) begin
                    state_d = S_TRAP;
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end
            S_WB: begin
                state_d = S_IF;
                retire  = 1'b1;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        instCnt_d = retire ? instCnt_q + 32'd1 : instCnt_q;
    end

    // Sequencer state, MEM wait counter and retire counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IF;
            waitCnt_q <= 8'd0;
            instCnt_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            instCnt_q <= instCnt_d;
        end
    end

    // Per-state datapath strobes. The reset term pulls them low at once, even in the middle of a cycle.
    always_comb begin
        bus.InstM_R   = 1'b0;
        bus.IR_W      = 1'b0;
        bus.PC_W      = 1'b0;
        bus.PC_Src    = 2'b00;
        bus.ALUCtrl   = 3'b000;
        bus.ALUSrcB   = 1'b0;
        bus.ExtSigned = 1'b0;
        bus.RegDst    = 1'b0;
        bus.MemtoReg  = 1'b0;
        bus.RF_W      = 1'b0;
        bus.DataM_CS  = 1'b0;
        bus.DataM_R   = 1'b0;
        bus.DataM_W   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IF: begin
                    bus.InstM_R = 1'b1;
                    bus.IR_W    = 1'b1;
                    bus.PC_W    = 1'b1;
                end
                S_ID: begin
                    if (isJ) begin
                        bus.PC_W   = 1'b1;
                        bus.PC_Src = 2'b10;
                    end
                end
                S_EX: begin
                    if (isSubu || isBeq) begin
                        bus.ALUCtrl = 3'b001;
                    end else if (isOri) begin
                        bus.ALUCtrl = 3'b010;
                    end else if (isSll) begin
                        bus.ALUCtrl = 3'b011;
                    end
                    bus.ALUSrcB   = isOri || isLw || isSw;
                    bus.ExtSigned = isLw || isSw;
                    if (isBeq && bus.zero) begin
                        bus.PC_W   = 1'b1;
                        bus.PC_Src = 2'b01;
                    end
                end
                S_MEM: begin
                    // The address operands from EX (add, signed immediate) stay held so the address does not move.
                    bus.ALUSrcB   = 1'b1;
                    bus.ExtSigned = 1'b1;
                    bus.DataM_CS  = 1'b1;
                    bus.DataM_R   = isLw;
                    bus.DataM_W   = isSw;
                end
                S_WB: begin
                    bus.RF_W     = 1'b1;
                    bus.RegDst   = isOri || isLw;
                    bus.MemtoReg = isLw;
                end
                default: ;
            endcase
        end
    end

    assign bus.state    = state_q;
    assign bus.trap     = (state_q == S_TRAP);
    assign bus.inst_cnt = instCnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl.
// Stimulus drives the inputs for one cycle at a time and queues the outputs expected in that cycle.
// A monitor pops the queue at each falling edge and compares.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // 100 MHz free-running clock
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Control vector bit order:
    // {InstM_R, IR_W, PC_W, PC_Src[1:0], ALUCtrl[2:0], ALUSrcB, ExtSigned, RegDst, MemtoReg, RF_W, DataM_CS, DataM_R, DataM_W}
    localparam logic [15:0] C_NONE     = 16'b000_00_000_0000_0_000;
    localparam logic [15:0] C_IF       = 16'b111_00_000_0000_0_000;
    localparam logic [15:0] C_J_ID     = 16'b001_10_000_0000_0_000;
    localparam logic [15:0] C_ADD_EX   = 16'b000_00_000_0000_0_000;
    localparam logic [15:0] C_SUB_EX   = 16'b000_00_001_0000_0_000;
    localparam logic [15:0] C_SLL_EX   = 16'b000_00_011_0000_0_000;
    localparam logic [15:0] C_ORI_EX   = 16'b000_00_010_1000_0_000;
    localparam logic [15:0] C_LWSW_EX  = 16'b000_00_000_1100_0_000;
    localparam logic [15:0] C_BEQ_T_EX = 16'b001_01_001_0000_0_000;
    localparam logic [15:0] C_BEQ_F_EX = 16'b000_00_001_0000_0_000;
    localparam logic [15:0] C_LW_MEM   = 16'b000_00_000_1000_0_110;
    localparam logic [15:0] C_SW_MEM   = 16'b000_00_000_1000_0_101;
    localparam logic [15:0] C_R_WB     = 16'b000_00_000_0000_1_000;
    localparam logic [15:0] C_ORI_WB   = 16'b000_00_000_0010_1_000;
    localparam logic [15:0] C_LW_WB    = 16'b000_00_000_0011_1_000;

    localparam logic [15:0] M_ALL      = 16'hFFFF;
    localparam logic [15:0] M_NOEXT    = 16'hFFBF;
    localparam logic [15:0] M_NOPCSRC  = 16'hE7FF;

    localparam logic [31:0] I_ADDU  = 32'h0085_1021;
    localparam logic [31:0] I_SUBU  = 32'h0085_1023;
    localparam logic [31:0] I_SLL   = 32'h0002_1080;
    localparam logic [31:0] I_ORI   = 32'h3482_0005;
    localparam logic [31:0] I_LW    = 32'h8C82_0004;
    localparam logic [31:0] I_SW    = 32'hAC82_0004;
    localparam logic [31:0] I_BEQ   = 32'h1085_0003;
    localparam logic [31:0] I_J     = 32'h0800_0010;
    localparam logic [31:0] I_BADOP = 32'hFC00_0000;
    localparam logic [31:0] I_BADFN = 32'h0000_0022;

    typedef struct {
        logic [2:0]  st;
        logic [15:0] ctl;
        logic [15:0] msk;
        logic        trp;
        logic [31:0] cnt;
        string       nm;
    } exp_t;

    exp_t        expQ[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] expCnt   = 32'd0;

    task automatic checkField(input string nm, input string fld,
                              input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s %s got=%h want=%h", nm, fld, got, want);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        logic [15:0] act;
        act = {bus.InstM_R, bus.IR_W, bus.PC_W, bus.PC_Src, bus.ALUCtrl, bus.ALUSrcB,
               bus.ExtSigned, bus.RegDst, bus.MemtoReg, bus.RF_W,
               bus.DataM_CS, bus.DataM_R, bus.DataM_W};
        checkField(e.nm, "state", {29'd0, bus.state}, {29'd0, e.st});
        checkField(e.nm, "ctrl", {16'd0, act & e.msk}, {16'd0, e.ctl & e.msk});
        checkField(e.nm, "trap", {31'd0, bus.trap}, {31'd0, e.trp});
        checkField(e.nm, "inst_cnt", bus.inst_cnt, e.cnt);
    endtask

    // Monitor: sample mid-cycle, well away from the rising edge
    always @(negedge clk) begin
        if (expQ.size() != 0) checkOutput(expQ.pop_front());
    end

    // One clock cycle of stimulus plus the outputs expected during it
    task automatic applyStimulus(input logic [31:0] instV, input logic rs, input logic dmr,
                                 input logic zr, input logic [2:0] es, input logic [15:0] ec,
                                 input logic [15:0] em, input logic ret, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = rs;
        bus.inst     = instV;
        bus.dm_ready = dmr;
        bus.zero     = zr;
        if (rs) expCnt = 32'd0;
        e.st  = es;
        e.ctl = ec;
        e.msk = em;
        e.trp = (es == 3'd7);
        e.cnt = expCnt;
        e.nm  = nm;
        expQ.push_back(e);
        if (ret) expCnt = expCnt + 32'd1;
    endtask

    task automatic resetCycle(input string nm);
        applyStimulus(32'd0, 1'b1, 1'b0, 1'b0, 3'd0, C_NONE, M_ALL, 1'b0, nm);
    endtask

    task automatic fetchDecode(input logic [31:0] instV, input string nm);
        applyStimulus(instV, 1'b0, 1'b0, 1'b0, 3'd0, C_IF, M_ALL, 1'b0, {nm, " IF"});
        applyStimulus(instV, 1'b0, 1'b0, 1'b0, 3'd1, C_NONE, M_ALL, 1'b0, {nm, " ID"});
    endtask

    task automatic runAlu(input logic [31:0] instV, input logic [15:0] exCtl,
                          input logic [15:0] wbCtl, input string nm);
        fetchDecode(instV, nm);
        applyStimulus(instV, 1'b0, 1'b0, 1'b0, 3'd2, exCtl, M_ALL, 1'b0, {nm, " EX"});
        applyStimulus(instV, 1'b0, 1'b0, 1'b0, 3'd4, wbCtl, M_ALL, 1'b1, {nm, " WB"});
    endtask

    // Memory op: waits cycles of dm_ready low, then one ready cycle unless ready is never given
    task automatic runMem(input logic [31:0] instV, input logic isLoad, input int waits,
                          input logic giveReady, input string nm);
        logic [15:0] memCtl;
        memCtl = isLoad ? C_LW_MEM : C_SW_MEM;
        fetchDecode(instV, nm);
        applyStimulus(instV, 1'b0, 1'b1, 1'b0, 3'd2, C_LWSW_EX, M_ALL, 1'b0, {nm, " EX"});
        for (int i = 0; i < waits; i++)
            applyStimulus(instV, 1'b0, 1'b0, 1'b0, 3'd3, memCtl, M_NOEXT, 1'b0, {nm, " MEMwait"});
        if (giveReady) begin
            applyStimulus(instV, 1'b0, 1'b1, 1'b0, 3'd3, memCtl, M_NOEXT, !isLoad, {nm, " MEMready"});
            if (isLoad)
                applyStimulus(instV, 1'b0, 1'b0, 1'b0, 3'd4, C_LW_WB, M_ALL, 1'b1, {nm, " WB"});
        end
    endtask

    task automatic runBeq(input logic z, input string nm);
        fetchDecode(I_BEQ, nm);
        if (z)
            applyStimulus(I_BEQ, 1'b0, 1'b0, 1'b1, 3'd2, C_BEQ_T_EX, M_ALL, 1'b1, {nm, " EX"});
        else
            applyStimulus(I_BEQ, 1'b0, 1'b0, 1'b0, 3'd2, C_BEQ_F_EX, M_NOPCSRC, 1'b1, {nm, " EX"});
    endtask

    task automatic trapCycles(input logic [31:0] instV, input int n, input string nm);
        for (int i = 0; i < n; i++)
            applyStimulus(instV, 1'b0, i[0], i[1], 3'd7, C_NONE, M_ALL, 1'b0, {nm, " TRAP"});
    endtask

    initial begin
        bus.inst     = 32'd0;
        bus.dm_ready = 1'b0;
        bus.zero     = 1'b0;

        resetCycle("reset0");
        resetCycle("reset1");

        runAlu(I_ADDU, C_ADD_EX, C_R_WB, "addu");
        runAlu(I_SUBU, C_SUB_EX, C_R_WB, "subu");
        runAlu(I_SLL, C_SLL_EX, C_R_WB, "sll");
        runAlu(I_ORI, C_ORI_EX, C_ORI_WB, "ori");
        runMem(I_LW, 1'b1, 3, 1'b1, "lw_w3");
        runMem(I_LW, 1'b1, 0, 1'b1, "lw_w0");
        runMem(I_SW, 1'b0, 2, 1'b1, "sw_w2");
        runBeq(1'b1, "beq_taken");
        runBeq(1'b0, "beq_not");

        // Jump, with the retire counter preloaded to all ones so that the retire wraps it to zero
        applyStimulus(I_J, 1'b0, 1'b0, 1'b0, 3'd0, C_IF, M_ALL, 1'b0, "j_wrap IF");
        @(negedge clk);
        #1;
        dut.instCnt_q = 32'hFFFF_FFFF;
        expCnt        = 32'hFFFF_FFFF;
        applyStimulus(I_J, 1'b0, 1'b0, 1'b0, 3'd1, C_J_ID, M_ALL, 1'b1, "j_wrap ID");
        runAlu(I_ADDU, C_ADD_EX, C_R_WB, "after_wrap");

        // Reset in the middle of MEM drops the strobes immediately and leaves no partial retire
        runMem(I_LW, 1'b1, 1, 1'b0, "lw_rst");
        resetCycle("rst_midmem");

        // Store that never completes: 16 MEM cycles, then TRAP
        runMem(I_SW, 1'b0, 16, 1'b0, "sw_timeout");
        trapCycles(I_SW, 3, "sw_timeout");
        resetCycle("rst_after_timeout");

        // Ready arriving on the 16th MEM cycle still completes the store
        runMem(I_SW, 1'b0, 15, 1'b1, "sw_late_ready");

        // Illegal opcode traps after ID and stays there until reset
        fetchDecode(I_BADOP, "bad_op");
        trapCycles(I_BADOP, 20, "bad_op");
        resetCycle("rst_after_badop");

        // Illegal R-type function code
        fetchDecode(I_BADFN, "bad_fn");
        trapCycles(I_BADFN, 2, "bad_fn");
        resetCycle("rst_after_badfn");

        runAlu(I_ORI, C_ORI_EX, C_ORI_WB, "ori_final");

        @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain got=%0d want=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
